// File: rtl/regbus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | regbus_initiator: queued single-word read/write initiator with timeout |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module regbus_initiator #(
  parameter int ADDR_WIDTH     = 14,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_write_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  wr_o,
  output logic [31:0]           wr_data_o,
  input  logic                  wr_ack_i,
  output logic                  rd_o,
  input  logic                  rd_ack_i,
  input  logic [31:0]           rd_data_i,
  output logic                  busy_o,
  output logic [15:0]           timeout_cnt_o
);

  localparam int          PW         = $clog2(CMD_DEPTH);
  localparam logic [PW:0] C_DEPTH    = (PW+1)'(CMD_DEPTH);
  localparam logic [15:0] C_TIMEOUT  = 16'(TIMEOUT_CYCLES);
  localparam logic [31:0] C_TMO_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } cmd_t;

  cmd_t                  mem_q [CMD_DEPTH];
  cmd_t                  mem_d [CMD_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  cmd_ready_q, cmd_ready_d;
  state_t                state_q, state_d;
  logic                  txn_write_q, txn_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wr_q, wr_d, rd_q, rd_d;
  logic [15:0]           wait_cnt_q, wait_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  busy_q, busy_d;
  logic                  push, pop;
  cmd_t                  head;

  always_comb begin
    mem_d         = mem_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    state_d       = state_q;
    txn_write_d   = txn_write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wr_d          = 1'b0;
    rd_d          = 1'b0;
    wait_cnt_d    = wait_cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    tmo_cnt_d     = tmo_cnt_q;
    push          = cmd_valid_i & cmd_ready_q;
    pop           = 1'b0;
    head          = mem_q[rptr_q];

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Only the ack matching the transaction direction completes it.
        if (txn_write_q ? wr_ack_i : rd_ack_i) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = txn_write_q;
          rsp_rdata_d   = txn_write_q ? 32'h0 : rd_data_i;
          rsp_timeout_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
          if (wait_cnt_d == C_TIMEOUT) begin
            state_d       = S_RESP;
            rsp_valid_d   = 1'b1;
            rsp_write_d   = txn_write_q;
            rsp_rdata_d   = C_TMO_DATA;
            rsp_timeout_d = 1'b1;
            tmo_cnt_d     = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (count_q != '0) pop = 1'b1;
          else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop loads the transaction registers and raises the strobe for ISSUE.
    if (pop) begin
      state_d     = S_ISSUE;
      txn_write_d = head.write;
      addr_d      = head.addr;
      wdata_d     = head.wdata;
      wr_d        = head.write;
      rd_d        = ~head.write;
      rptr_d      = rptr_q + 1'b1;
    end

    if (push) begin
      mem_d[wptr_q] = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
      wptr_d        = wptr_q + 1'b1;
    end

    count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);
    cmd_ready_d = (count_d != C_DEPTH);
    busy_d      = (count_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      cmd_ready_q   <= 1'b0;
      state_q       <= S_IDLE;
      txn_write_q   <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      wait_cnt_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      cmd_ready_q   <= cmd_ready_d;
      state_q       <= state_d;
      txn_write_q   <= txn_write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      wait_cnt_q    <= wait_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_write_o   = rsp_write_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign addr_o        = addr_q;
  assign wr_o          = wr_q;
  assign wr_data_o     = wdata_q;
  assign rd_o          = rd_q;
  assign busy_o        = busy_q;
  assign timeout_cnt_o = tmo_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regbus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_regbus_initiator: self-checking bench for regbus_initiator          |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_regbus_initiator;

  localparam int NR = 150;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
  logic [13:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_write_o, rsp_timeout_o;
  logic [31:0] rsp_rdata_o;
  logic [13:0] addr_o;
  logic        wr_o, rd_o, wr_ack_i, rd_ack_i, busy_o;
  logic [31:0] wr_data_o, rd_data_i;
  logic [15:0] timeout_cnt_o;

  logic        auto_wr_ack = 1'b0, auto_rd_ack = 1'b0, man_wr_ack = 1'b0, man_rd_ack = 1'b0;
  logic [31:0] auto_rd_data = '0;
  assign wr_ack_i  = auto_wr_ack | man_wr_ack;
  assign rd_ack_i  = auto_rd_ack | man_rd_ack;
  assign rd_data_i = auto_rd_data;

  regbus_initiator #(.ADDR_WIDTH(14), .CMD_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_timeout_o(rsp_timeout_o),
    .addr_o(addr_o), .wr_o(wr_o), .wr_data_o(wr_data_o), .wr_ack_i(wr_ack_i),
    .rd_o(rd_o), .rd_ack_i(rd_ack_i), .rd_data_i(rd_data_i),
    .busy_o(busy_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk = ~clk;

  // Responder contents: a fixed function of the address.
  function automatic logic [31:0] rdval(input logic [13:0] a);
    return 32'h1234_5678 ^ {18'h0, a} ^ 32'h12;
  endfunction

  // Responder: addresses ending in 0xF never ack (but see two wrong-direction
  // acks); others ack with the matching line addr[1:0]+1 cycles after the strobe.
  logic       pend = 1'b0, pwrite = 1'b0;
  int         pcnt = 0, sp = 0;
  logic [13:0] paddr = '0;
  always @(negedge clk) begin
    auto_wr_ack = 1'b0;
    auto_rd_ack = 1'b0;
    if (rst_i) begin
      pend = 1'b0;
      sp   = 0;
    end else begin
      if (pend) begin
        pcnt--;
        if (pcnt == 0) begin
          pend = 1'b0;
          if (pwrite) auto_wr_ack = 1'b1;
          else begin
            auto_rd_ack  = 1'b1;
            auto_rd_data = rdval(paddr);
          end
        end
      end
      if (sp > 0) begin
        sp--;
        if (pwrite) auto_rd_ack = 1'b1;
        else auto_wr_ack = 1'b1;
      end
      if (wr_o || rd_o) begin
        pwrite = wr_o;
        paddr  = addr_o;
        if (addr_o[3:0] == 4'hF) sp = 2;
        else begin
          pend = 1'b1;
          pcnt = int'(addr_o[1:0]) + 1;
        end
      end
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One command on an idle initiator; latencies counted in cycles from the accept edge.
  task automatic do_txn(input logic w, input logic [13:0] a, input logic [31:0] d,
                        output logic rw, output logic [31:0] rr, output logic rt,
                        output int ts, output int tr, output int nstb, output logic [47:0] sv);
    int n;
    rw = 1'b0; rr = '0; rt = 1'b0; ts = -1; tr = -1; nstb = 0; sv = '0;
    @(negedge clk);
    rsp_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a; cmd_wdata_i = d;
    n = 0;
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    n = 1;
    while (n < 100) begin
      if (wr_o || rd_o) begin
        nstb++;
        if (ts < 0) begin
          ts = n;
          sv = {wr_o, rd_o, addr_o, wr_data_o};
        end
      end
      if (rsp_valid_o) begin
        rw = rsp_write_o; rr = rsp_rdata_o; rt = rsp_timeout_o; tr = n;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic        w;
    logic [13:0] a;
    logic [31:0] d;
    logic        ew;
    logic [31:0] er;
    logic        et;
    int          lat;
  } vec_t;

  typedef struct packed { logic w; logic [13:0] a; logic [31:0] d; } cmd_t;
  typedef struct packed { logic w; logic [31:0] r; logic t; } rsp_t;

  vec_t        tv [8];
  cmd_t        sq [$];
  rsp_t        rq [$];
  cmd_t        ce;
  rsp_t        re;
  logic        rw, rt, seen, acc, rdy_chk;
  logic [31:0] rr;
  logic [47:0] sv;
  int          ts, tr, nstb, nacc, got, c, sent, cyc;
  logic [15:0] exp_tmo = '0;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=stuck required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tv[0] = '{1'b1, 14'h0010, 32'hA5A5_0001, 1'b1, 32'h0000_0000, 1'b0, 2};
    tv[1] = '{1'b0, 14'h0012, 32'h0000_0000, 1'b0, 32'h1234_5678, 1'b0, 4};
    tv[2] = '{1'b0, 14'h001F, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b1, 17};
    tv[3] = '{1'b1, 14'h0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 2};
    tv[4] = '{1'b0, 14'h0000, 32'h0000_0000, 1'b0, 32'h1234_566A, 1'b0, 2};
    tv[5] = '{1'b0, 14'h3FFE, 32'h0000_0000, 1'b0, 32'h1234_6994, 1'b0, 4};
    tv[6] = '{1'b1, 14'h002F, 32'h1111_2222, 1'b1, 32'hDEAD_BEEF, 1'b1, 17};
    tv[7] = '{1'b1, 14'h3FFE, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 4};

    // Reset state
    #1 rst_i = 1'b1;
    #3;
    chk("rst_ctrl", {cmd_ready_o, rsp_valid_o, rsp_write_o, rsp_timeout_o, wr_o, rd_o, busy_o,
                     timeout_cnt_o, addr_o}, '0);
    chk("rst_data", {rsp_rdata_o, wr_data_o}, '0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {cmd_ready_o, busy_o}, 2'b10);

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      do_txn(tv[i].w, tv[i].a, tv[i].d, rw, rr, rt, ts, tr, nstb, sv);
      chk($sformatf("vec%0d_rsp", i), {rw, rr, rt}, {tv[i].ew, tv[i].er, tv[i].et});
      chk($sformatf("vec%0d_strobe_lat", i), ts, 2);
      chk($sformatf("vec%0d_rsp_lat", i), tr - ts, tv[i].lat);
      chk($sformatf("vec%0d_nstrobe", i), nstb, 1);
      chk($sformatf("vec%0d_strobe", i), sv, {tv[i].w, ~tv[i].w, tv[i].a, tv[i].d});
      if (tv[i].et) exp_tmo++;
    end
    chk("tmo_cnt_table", timeout_cnt_o, exp_tmo);

    // Late ack after a timeout is ignored; the next command works
    do_txn(1'b0, 14'h003F, 32'h0, rw, rr, rt, ts, tr, nstb, sv);
    exp_tmo++;
    chk("late_rsp", {rw, rr, rt}, {1'b0, 32'hDEAD_BEEF, 1'b1});
    chk("late_tmo_cnt", timeout_cnt_o, exp_tmo);
    repeat (3) @(negedge clk);
    man_rd_ack = 1'b1;
    @(negedge clk);
    man_rd_ack = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_o || busy_o) seen = 1'b1;
    end
    chk("late_ack_ignored", seen, 1'b0);
    chk("late_tmo_cnt2", timeout_cnt_o, exp_tmo);
    do_txn(1'b0, 14'h0012, 32'h0, rw, rr, rt, ts, tr, nstb, sv);
    chk("after_late_rsp", {rw, rr, rt}, {1'b0, 32'h1234_5678, 1'b0});

    // Backpressure: fill FIFO plus one in flight
    @(negedge clk);
    rsp_ready_i = 1'b0;
    nacc = 0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 14'h0020; cmd_wdata_i = 32'h0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_ready_o) nacc++;
      @(negedge clk);
      cmd_addr_i = 14'h0020 + 14'(nacc);
    end
    cmd_valid_i = 1'b0;
    chk("bp_accepted", nacc, 5);
    chk("bp_ready_low", cmd_ready_o, 1'b0);
    rsp_ready_i = 1'b1;
    got = 0; c = 0; rdy_chk = 1'b0;
    while (got < 5 && c < 300) begin
      if (got == 1 && !rdy_chk) begin
        chk("bp_ready_back", cmd_ready_o, 1'b1);
        rdy_chk = 1'b1;
      end
      if (rsp_valid_o) begin
        chk($sformatf("bp_rsp%0d", got), {rsp_write_o, rsp_rdata_o, rsp_timeout_o},
            {1'b0, rdval(14'h0020 + 14'(got)), 1'b0});
        got++;
      end
      @(negedge clk);
      c++;
    end
    chk("bp_count", got, 5);

    // Randomized traffic against the queue model
    sent = 0; cyc = 0; acc = 1'b0;
    while ((sent < NR || rq.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (wr_o || rd_o) begin
        if (sq.size() == 0) chk("rnd_strobe_unexpected", {wr_o, rd_o}, 2'b00);
        else begin
          ce = sq.pop_front();
          chk("rnd_strobe", {wr_o, rd_o, addr_o, wr_data_o}, {ce.w, ~ce.w, ce.a, ce.d});
        end
      end
      if (acc) begin
        cmd_valid_i = 1'b0;
        acc = 1'b0;
      end
      if (!cmd_valid_i && sent < NR && $urandom_range(0, 2) != 0) begin
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'($urandom_range(0, 1));
        cmd_addr_i  = 14'($urandom);
        cmd_wdata_i = $urandom;
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      if (cmd_valid_i && cmd_ready_o) begin
        sq.push_back('{cmd_write_i, cmd_addr_i, cmd_wdata_i});
        if (cmd_addr_i[3:0] == 4'hF) begin
          rq.push_back('{cmd_write_i, 32'hDEAD_BEEF, 1'b1});
          exp_tmo++;
        end else
          rq.push_back('{cmd_write_i, cmd_write_i ? 32'h0 : rdval(cmd_addr_i), 1'b0});
        sent++;
        acc = 1'b1;
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (rq.size() == 0) chk("rnd_rsp_unexpected", rsp_valid_o, 1'b0);
        else begin
          re = rq.pop_front();
          chk("rnd_rsp", {rsp_write_o, rsp_rdata_o, rsp_timeout_o}, {re.w, re.r, re.t});
        end
      end
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("rnd_budget", (cyc < 20000), 1'b1);
    chk("rnd_tmo_cnt", timeout_cnt_o, exp_tmo);

    // Asynchronous reset during WAIT with two commands queued
    rsp_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 14'h001F; cmd_wdata_i = 32'h5555_AAAA;
    nacc = 0; c = 0;
    while (nacc < 3 && c < 50) begin
      if (cmd_ready_o) nacc++;
      @(negedge clk);
      c++;
      cmd_addr_i = 14'h0030 + 14'(nacc);
    end
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_ctrl", {cmd_ready_o, rsp_valid_o, rsp_write_o, rsp_timeout_o, wr_o, rd_o, busy_o,
                        timeout_cnt_o, addr_o}, '0);
    chk("midrst_data", {rsp_rdata_o, wr_data_o}, '0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid_o || busy_o) seen = 1'b1;
    end
    chk("post_rst_quiet", seen, 1'b0);
    do_txn(1'b1, 14'h0044, 32'hCAFE_F00D, rw, rr, rt, ts, tr, nstb, sv);
    chk("post_rst_rsp", {rw, rr, rt}, {1'b1, 32'h0, 1'b0});
    chk("post_rst_strobe", sv, {1'b1, 1'b0, 14'h0044, 32'hCAFE_F00D});
    chk("post_rst_tmo_cnt", timeout_cnt_o, 16'h0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regbus_initiator.md
Name: regbus_initiator

Overview:
- Bus initiator for the user register interface: it drives the address, write-strobe and read-strobe lines and waits for the ack lines.
- Accepts single-word read/write commands through a valid/ready port and buffers them in a small command FIFO.
- Issues one bus transaction at a time, waits for the matching ack (with timeout) and returns one response per command through a valid/ready response port.
- Sits between a host command source (test sequencer, soft CPU bridge) and the user register file.

Parameters:
- ADDR_WIDTH, 14, width of the bus address and of cmd_addr_i.
- CMD_DEPTH, 4, command FIFO entries; power of two, >= 2.
- TIMEOUT_CYCLES, 16, WAIT-state cycles without a matching ack before timing out; 2..65535.

Ports:
- clk  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i  in  32  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_write_o  out  1  response belongs to a write
- rsp_rdata_o  out  32  read data; 0 for writes
- rsp_timeout_o  out  1  transaction timed out
- addr_o  out  ADDR_WIDTH  bus address
- wr_o  out  1  write strobe
- wr_data_o  out  32  bus write data
- wr_ack_i  in  1  write ack from responder
- rd_o  out  1  read strobe
- rd_ack_i  in  1  read ack from responder
- rd_data_i  in  32  read data, valid in the cycle rd_ack_i=1
- busy_o  out  1  FIFO non-empty or FSM not IDLE
- timeout_cnt_o  out  16  saturating count of timeouts

Behaviour:
- Reset: asynchronous, takes effect immediately. All outputs go to 0 (cmd_ready_o=0 while rst_i=1, then 1 from the first cycle after release). FIFO is emptied, FSM goes to IDLE, timeout_cnt_o=0. A transaction in flight is abandoned and no response is produced for it.
- FIFO:
  - cmd_ready_o = !full (registered count).
  - Push on cmd_valid_i & cmd_ready_o.
  - Pop on the IDLE->ISSUE transition.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head into the transaction registers (write, addr, wdata) and go to ISSUE. Otherwise stay.
- ISSUE:
  - Exactly one cycle. wr_o=1 (write) or rd_o=1 (read); never both.
  - addr_o and wr_data_o are driven from the transaction registers and held stable until leaving WAIT.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - Strobes are 0.
  - A matching ack (wr_ack_i for a write, rd_ack_i for a read) moves to RESP with timeout=0. For a read, rd_data_i is captured in that same cycle. For a write, rdata=0.
  - Non-matching acks are ignored.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES, go to RESP with timeout=1, rdata=32'hDEADBEEF, and increment timeout_cnt_o (saturating at 16'hFFFF).
  - A matching ack in the same cycle the limit is reached wins: no timeout.
- RESP:
  - rsp_valid_o=1 with rsp_write_o, rsp_rdata_o and rsp_timeout_o stable until rsp_ready_i.
  - On the handshake: if the FIFO is non-empty, pop and go directly to ISSUE; otherwise go to IDLE.
  - Acks arriving outside WAIT (late acks after a timeout) are ignored.
- Latency: with a responder that acks 1 cycle after the strobe and rsp_ready_i=1, the strobe occurs 2 cycles after the command is accepted (push, then IDLE pop, then ISSUE). rsp_valid_o rises 2 cycles after the strobe cycle. Back-to-back throughput is 1 transaction per 3 cycles.
- Responses are returned in command order; there is exactly one response per accepted command unless reset intervenes.

Test Plan:
- Write: cmd write addr=0x10 wdata=0xA5A5_0001; responder acks 1 cycle later -> wr_o high for exactly 1 cycle with addr_o=0x10 and wr_data_o=0xA5A5_0001. Response: write=1, rdata=0, timeout=0. rd_o never asserted.
- Read: responder returns 0x1234_5678 for addr 0x12 with rd_ack_i -> single rd_o pulse. Response: write=0, rdata=0x1234_5678, timeout=0.
- Timeout: responder never acks, TIMEOUT_CYCLES=16 -> rsp_valid_o 16 WAIT cycles after the strobe, with timeout=1, rdata=0xDEADBEEF, timeout_cnt_o=1. An ack injected 3 cycles later changes nothing, and the next command completes normally.
- Backpressure/full: rsp_ready_i=0, cmd_valid_i held high with distinct commands -> exactly 5 accepted (1 in flight + 4 buffered) before cmd_ready_o=0. Releasing rsp_ready_i then yields 5 responses in order, with cmd_ready_o returning to 1 after the first pop.
- Wrong ack: read in flight and responder pulses wr_ack_i only -> no response until the timeout.
- Reset mid-WAIT: assert rst_i asynchronously during WAIT with 2 commands queued -> all outputs 0 immediately. After release: busy_o=0, no responses emitted, and a new command completes normally.
